orbit_ball: RTL and testbench

- Parametrised player sprite that travels on a fixed circle. Motion is driven by the keyboard keycode and updated once per frame.
- Position is held as an angular phase with a fractional part. X/Y come from a quarter-wave sine table, and speed ramps with acceleration.
- An ALIVE/DEAD state machine handles hit and respawn.
- Sits between the keyboard keycode register and the colour mapper / collision logic. Instantiated once per player, with a different START_ANGLE for each.

---
 rtl/orbit_ball.sv | 159 +++++++++++++++
 tb/tb_orbit_ball.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/orbit_ball.sv
// orbit_ball: player sprite moving on a fixed circle, one update per frame.
// Position is an angular phase with FRAC_W fractional bits; X/Y are derived
// from a quarter-wave sine table. Holding a direction key ramps speed up to
// MAX_SPEED; reversing restarts the ramp. A hit kills the sprite until respawn.
//
// state    | meaning
// ST_ALIVE | keys move the sprite, hit kills it
// ST_DEAD  | position frozen, waiting for respawn
module orbit_ball #(
    parameter int         CENTER_X    = 320,
    parameter int         CENTER_Y    = 240,
    parameter int         RADIUS      = 80,
    parameter int         START_ANGLE = 0,
    parameter int         FRAC_W      = 4,
    parameter int         ACCEL       = 1,
    parameter int         MAX_SPEED   = 16,
    parameter int         BALL_SIZE   = 4,
    parameter logic [7:0] KEY_CW      = 8'd7,
    parameter logic [7:0] KEY_CCW     = 8'd4
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       hit,
    input  logic       respawn,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic [5:0] Angle,
    output logic       Alive
);

    localparam int PW = 6 + FRAC_W;

    localparam logic [0:0] ST_DEAD  = 1'b0;
    localparam logic [0:0] ST_ALIVE = 1'b1;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    localparam logic [5:0]    ANGLE_START = 6'(START_ANGLE);
    localparam logic [PW-1:0] PHASE_START = PW'(START_ANGLE * (2 ** FRAC_W));

    // First quadrant of round(256*sin(2*pi*q/64)), q = 0..16
    function automatic int sin_lut(input logic [4:0] q);
        case (q)
            5'd0:    return 0;
            5'd1:    return 25;
            5'd2:    return 50;
            5'd3:    return 74;
            5'd4:    return 98;
            5'd5:    return 121;
            5'd6:    return 142;
            5'd7:    return 162;
            5'd8:    return 181;
            5'd9:    return 198;
            5'd10:   return 213;
            5'd11:   return 226;
            5'd12:   return 237;
            5'd13:   return 245;
            5'd14:   return 251;
            5'd15:   return 255;
            default: return 256;
        endcase
    endfunction

    // Signed sine over the full 64-step circle by quadrant folding
    function automatic int sin_val(input logic [5:0] a);
        logic [4:0] q;
        q = a[4] ? (5'd16 - {1'b0, a[3:0]}) : {1'b0, a[3:0]};
        return a[5] ? -sin_lut(q) : sin_lut(q);
    endfunction

    // Arithmetic shift floors toward minus infinity, so negative offsets round down
    function automatic logic [9:0] pos_x(input logic [5:0] a);
        int v;
        v = CENTER_X + ((RADIUS * sin_val(a + 6'd16)) >>> 8);
        return v[9:0];
    endfunction

    function automatic logic [9:0] pos_y(input logic [5:0] a);
        int v;
        v = CENTER_Y + ((RADIUS * sin_val(a)) >>> 8);
        return v[9:0];
    endfunction

    logic [PW-1:0] phase, phase_n;
    logic [7:0]    speed, speed_n;
    logic          dir, dir_n;
    logic [0:0]    state, state_n;

    // Next phase/speed/direction/state for the coming frame edge
    always_comb begin
        phase_n = phase;
        speed_n = speed;
        dir_n   = dir;
        state_n = state;
        case (state)
            ST_ALIVE: begin
                if (hit) begin
                    state_n = ST_DEAD;
                    speed_n = '0;
                end else if (keycode == KEY_CW) begin
                    if (dir == DIR_CW) begin
                        speed_n = (int'(speed) + ACCEL >= MAX_SPEED) ? 8'(MAX_SPEED)
                                                                    : 8'(int'(speed) + ACCEL);
                    end else begin
                        speed_n = 8'(ACCEL);
                        dir_n   = DIR_CW;
                    end
                    phase_n = phase + PW'(speed_n);
                end else if (keycode == KEY_CCW) begin
                    if (dir == DIR_CCW) begin
                        speed_n = (int'(speed) + ACCEL >= MAX_SPEED) ? 8'(MAX_SPEED)
                                                                    : 8'(int'(speed) + ACCEL);
                    end else begin
                        speed_n = 8'(ACCEL);
                        dir_n   = DIR_CCW;
                    end
                    phase_n = phase - PW'(speed_n);
                end else begin
                    speed_n = '0;
                end
            end
            default: begin
                if (respawn) begin
                    state_n = ST_ALIVE;
                    phase_n = PHASE_START;
                    speed_n = '0;
                    dir_n   = DIR_CW;
                end
            end
        endcase
    end

    // Frame-rate state registers; coordinates follow phase_n with no lag
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase <= PHASE_START;
            speed <= '0;
            dir   <= DIR_CW;
            state <= ST_ALIVE;
            BallX <= pos_x(ANGLE_START);
            BallY <= pos_y(ANGLE_START);
        end else begin
            phase <= phase_n;
            speed <= speed_n;
            dir   <= dir_n;
            state <= state_n;
            BallX <= pos_x(phase_n[PW-1:FRAC_W]);
            BallY <= pos_y(phase_n[PW-1:FRAC_W]);
        end
    end

    assign Angle = phase[PW-1:FRAC_W];
    assign Alive = (state == ST_ALIVE);
    assign BallS = 10'(BALL_SIZE);

endmodule

// File: tb/tb_orbit_ball.sv
// tb_orbit_ball: randomized frames against a trigonometric reference model,
// expectations queued at stimulus time and compared by a separate monitor.
module tb_orbit_ball;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       hit;
    logic       respawn;

    logic [9:0] x0, y0, s0, x1, y1, s1, x2, y2, s2;
    logic [5:0] a0, a1, a2;
    logic       l0, l1, l2;

    orbit_ball #(.START_ANGLE(0)) u0 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .hit(hit),
        .respawn(respawn), .BallX(x0), .BallY(y0), .BallS(s0), .Angle(a0), .Alive(l0));
    orbit_ball #(.START_ANGLE(40)) u1 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .hit(hit),
        .respawn(respawn), .BallX(x1), .BallY(y1), .BallS(s1), .Angle(a1), .Alive(l1));
    orbit_ball #(.START_ANGLE(32)) u2 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .hit(hit),
        .respawn(respawn), .BallX(x2), .BallY(y2), .BallS(s2), .Angle(a2), .Alive(l2));

    always #5 frame_clk = ~frame_clk;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int x0, y0, a0, l0, x1, y1, a1, l1;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    int start_a[2] = '{0, 40};
    int m_phase[2];
    int m_speed[2];
    int m_dir[2];     // 0 = clockwise, 1 = counter-clockwise
    int m_alive[2];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Screen coordinates straight from the circle equation with rounded sine
    function automatic int ref_x(input int a);
        real c;
        c = $floor(256.0 * $cos(2.0 * PI * a / 64.0) + 0.5);
        return (320 + $rtoi($floor(80.0 * c / 256.0))) & 1023;
    endfunction

    function automatic int ref_y(input int a);
        real s;
        s = $floor(256.0 * $sin(2.0 * PI * a / 64.0) + 0.5);
        return (240 + $rtoi($floor(80.0 * s / 256.0))) & 1023;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = start_a[i] * 16;
            m_speed[i] = 0;
            m_dir[i]   = 0;
            m_alive[i] = 1;
        end
    endtask

    task automatic model_step(input int k, input bit h, input bit r);
        for (int i = 0; i < 2; i++) begin
            if (m_alive[i] == 1) begin
                if (h) begin
                    m_speed[i] = 0;
                    m_alive[i] = 0;
                end else if (k == 7 || k == 4) begin
                    int want;
                    want = (k == 7) ? 0 : 1;
                    if (m_dir[i] == want) m_speed[i] = (m_speed[i] + 1 > 16) ? 16 : m_speed[i] + 1;
                    else begin
                        m_speed[i] = 1;
                        m_dir[i]   = want;
                    end
                    if (k == 7) m_phase[i] = (m_phase[i] + m_speed[i]) % 1024;
                    else        m_phase[i] = (m_phase[i] - m_speed[i] + 1024) % 1024;
                end else begin
                    m_speed[i] = 0;
                end
            end else if (r) begin
                m_phase[i] = start_a[i] * 16;
                m_speed[i] = 0;
                m_dir[i]   = 0;
                m_alive[i] = 1;
            end
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        e.a0 = m_phase[0] / 16;
        e.x0 = ref_x(e.a0);
        e.y0 = ref_y(e.a0);
        e.l0 = m_alive[0];
        e.a1 = m_phase[1] / 16;
        e.x1 = ref_x(e.a1);
        e.y1 = ref_y(e.a1);
        e.l1 = m_alive[1];
        return e;
    endfunction

    task automatic frame(input int k, input bit h, input bit r);
        @(negedge frame_clk);
        keycode = k[7:0];
        hit     = h;
        respawn = r;
        model_step(k, h, r);
        sb.push_back(make_exp());
    endtask

    // Wait until the edge consuming the last queued frame has been checked
    task automatic drain();
        @(posedge frame_clk);
        #2;
    endtask

    // Monitor: every frame edge presents new outputs
    initial begin
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("u0_x", int'(x0), e.x0);
                check("u0_y", int'(y0), e.y0);
                check("u0_angle", int'(a0), e.a0);
                check("u0_alive", int'(l0), e.l0);
                check("u1_x", int'(x1), e.x1);
                check("u1_y", int'(y1), e.y1);
                check("u1_angle", int'(a1), e.a1);
                check("u1_alive", int'(l1), e.l1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic random_frames(input int n);
        int k;
        int sel;
        k = 0;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: k = 7;
                4, 5, 6:    k = 4;
                7:          k = 0;
                8:          k = $urandom_range(0, 255);
                default:    ;
            endcase
            frame(k, ($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0));
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        keycode = 8'd0;
        hit     = 1'b0;
        respawn = 1'b0;
        model_reset();
        #12;
        check("rst_u0_x", int'(x0), 400);
        check("rst_u0_y", int'(y0), 240);
        check("rst_u0_angle", int'(a0), 0);
        check("rst_u0_alive", int'(l0), 1);
        check("rst_u0_size", int'(s0), 4);
        check("rst_u1_x", int'(x1), 263);
        check("rst_u1_y", int'(y1), 183);
        check("rst_u1_angle", int'(a1), 40);
        check("rst_u2_x", int'(x2), 240);
        check("rst_u2_y", int'(y2), 240);
        check("rst_u2_angle", int'(a2), 32);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        // speed ramp 1..16: phase reaches 136 (angle 8) after 16 frames
        for (int i = 0; i < 16; i++) frame(7, 0, 0);
        drain();
        check("ramp_angle8", int'(a0), 8);
        check("ramp_x376", int'(x0), 376);
        check("ramp_y296", int'(y0), 296);

        // saturated clockwise travel through 63 -> 0, then reverse through 0 -> 63
        for (int i = 0; i < 64; i++) frame(7, 0, 0);
        for (int i = 0; i < 40; i++) frame(4, 0, 0);
        for (int i = 0; i < 5; i++) frame(0, 0, 0);
        for (int i = 0; i < 20; i++) frame(7, 0, 0);
        frame(4, 0, 0);
        frame(4, 0, 0);

        // kill, keys ignored while dead, respawn with simultaneous hit
        frame(7, 1, 0);
        for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 7 : 4, 0, 0);
        frame(7, 1, 1);
        frame(7, 0, 1);
        frame(7, 0, 1);

        random_frames(400);

        // asynchronous reset between frame edges
        drain();
        #1;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("async_u0_x", int'(x0), 400);
        check("async_u0_angle", int'(a0), 0);
        check("async_u0_alive", int'(l0), 1);
        check("async_u1_x", int'(x1), 263);
        check("async_u1_y", int'(y1), 183);
        check("async_u1_angle", int'(a1), 40);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        random_frames(150);
        drain();
        check("queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
